// File: rtl/cubic_row_scheduler.sv
// Horizontal bicubic upscaler sequencer: builds a replicated-edge 4-sample window per
// source interval, evaluates the external coefficient unit's cubic by Horner per phase.
module cubic_row_scheduler #(
    parameter int unsigned bit_depth  = 8,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned SCALE_LOG2 = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bit_depth-1:0] in_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bit_depth-1:0] out_pixel,
    output logic                 out_last,
    output logic [bit_depth-1:0] co_a0,
    output logic [bit_depth-1:0] co_a1,
    output logic [bit_depth-1:0] co_a2,
    output logic [bit_depth-1:0] co_a3,
    input  logic [bit_depth+3:0] co_t0,
    input  logic [bit_depth+3:0] co_t1,
    input  logic [bit_depth+3:0] co_t2,
    input  logic [bit_depth+3:0] co_t3,
    output logic                 busy
);

    localparam int unsigned TW    = bit_depth + 4;
    localparam int unsigned AW    = bit_depth + SCALE_LOG2 + 8;
    localparam int unsigned PW    = AW + SCALE_LOG2 + 1;
    localparam int unsigned CW    = $clog2(WIDTH + 1);
    localparam int unsigned SCALE = 1 << SCALE_LOG2;

    localparam logic [SCALE_LOG2-1:0] K_MAX    = SCALE_LOG2'(SCALE - 1);
    localparam logic [CW-1:0]         COL_PRE  = CW'(2);
    localparam logic [CW-1:0]         COL_FULL = CW'(WIDTH);
    localparam logic signed [AW-1:0]  PIX_MAX  = AW'((1 << bit_depth) - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_H1, S_H2, S_H3, S_H4, S_OUT, S_LOAD, S_FLUSH
    } state_t;

    state_t state, next_state;

    logic [bit_depth-1:0]  w0, w1, w2, w3;
    logic [CW-1:0]         col_in;
    logic [SCALE_LOG2-1:0] k;
    logic [1:0]            flush_cnt;
    logic signed [AW-1:0]  acc;

    logic                  accept;
    logic [TW-1:0]         coef_sel;
    logic signed [AW-1:0]  coef_ext;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc_next;
    logic [bit_depth-1:0]  pix_clamp;

    assign accept = in_valid & in_ready;
    assign co_a0  = w0;
    assign co_a1  = w1;
    assign co_a2  = w2;
    assign co_a3  = w3;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_FILL;
            S_FILL:  if (accept && col_in == COL_PRE) next_state = S_H1;
            S_H1:    next_state = S_H2;
            S_H2:    next_state = S_H3;
            S_H3:    next_state = S_H4;
            S_H4:    next_state = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    if (k != K_MAX)              next_state = S_H1;
                    else if (flush_cnt == 2'd2)  next_state = S_IDLE;
                    else if (col_in < COL_FULL)  next_state = S_LOAD;
                    else                         next_state = S_FLUSH;
                end
            end
            S_LOAD:  if (accept) next_state = S_H1;
            S_FLUSH: next_state = S_H1;
            default: next_state = S_IDLE;
        endcase
    end

    // One Horner step: floor((acc*k)/SCALE) + coefficient of the current stage
    always_comb begin
        case (state)
            S_H1:    coef_sel = co_t3;
            S_H2:    coef_sel = co_t2;
            S_H3:    coef_sel = co_t1;
            default: coef_sel = co_t0;
        endcase
        coef_ext = AW'($signed(coef_sel));
        prod     = PW'(acc) * PW'($signed({1'b0, k}));
        acc_next = AW'(prod >>> SCALE_LOG2) + coef_ext;
        if (acc_next[AW-1])          pix_clamp = '0;
        else if (acc_next > PIX_MAX) pix_clamp = '1;
        else                         pix_clamp = bit_depth'(acc_next);
    end

    // Window, counters, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            w3        <= '0;
            col_in    <= '0;
            k         <= '0;
            flush_cnt <= '0;
            acc       <= '0;
            out_pixel <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready <= (next_state == S_IDLE) || (next_state == S_FILL) || (next_state == S_LOAD);
            busy     <= (next_state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        w0        <= in_pixel;
                        w1        <= in_pixel;
                        w2        <= in_pixel;
                        w3        <= in_pixel;
                        col_in    <= CW'(1);
                        flush_cnt <= '0;
                        k         <= '0;
                    end
                end
                S_FILL, S_LOAD: begin
                    if (accept) begin
                        w0     <= w1;
                        w1     <= w2;
                        w2     <= w3;
                        w3     <= in_pixel;
                        col_in <= col_in + CW'(1);
                        k      <= '0;
                    end
                end
                S_H1:       acc <= coef_ext;
                S_H2, S_H3: acc <= acc_next;
                S_H4: begin
                    acc       <= acc_next;
                    out_pixel <= pix_clamp;
                    out_valid <= 1'b1;
                    out_last  <= (flush_cnt == 2'd2) && (k == K_MAX);
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (k != K_MAX) k <= k + SCALE_LOG2'(1);
                    end
                end
                S_FLUSH: begin
                    // Past the row end: replicate the last pixel
                    w0        <= w1;
                    w1        <= w2;
                    w2        <= w3;
                    flush_cnt <= flush_cnt + 2'd1;
                    k         <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
